stream_comp_invoke: RTL and testbench

STREAM_COMP_INVOKE -- requirements
Module: stream_comp_invoke

---
 rtl/stream_comp_invoke.sv | 155 +++++++++++++++
 tb/tb_stream_comp_invoke.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_comp_invoke.sv
// Dataflow actor: SETUP_COMP pops `size` tokens into slots, COMP sums the slots,
// OUTPUT pushes the registered sum; each firing ends with a one-cycle FC pulse.
module stream_comp_invoke #(
  parameter int unsigned size  = 3,
  parameter int unsigned width = 16,
  localparam int unsigned lg     = (size == 1) ? 1 : $clog2(size),
  localparam int unsigned owidth = width + lg
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              invoke,
  input  logic [1:0]        next_mode_in,
  input  logic [width-1:0]  data_in,
  output logic              rd_in_fifo,
  output logic              wr_out_fifo,
  output logic [owidth-1:0] data_out,
  output logic [1:0]        next_mode_out,
  output logic              FC
);

  localparam int unsigned cw = (size <= 1) ? 1 : $clog2(size);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_COMP    = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] MODE_SETUP  = 2'b00;
  localparam logic [1:0] MODE_COMP   = 2'b01;
  localparam logic [1:0] MODE_OUTPUT = 2'b10;

  logic [2:0]        state, state_nx;
  logic [cw-1:0]     rd_cnt, rd_cnt_nx;
  logic [cw-1:0]     cap_idx, cap_idx_nx;
  logic              cap_vld;
  logic [1:0]        pend_mode, pend_nx;
  logic [owidth-1:0] sum_q, sum_nx, sum_c;
  logic [owidth-1:0] dout_nx;
  logic              rd_nx, wr_nx, fc_nx;
  logic [1:0]        mode_nx;
  logic [width-1:0]  slot [size];

  // Zero-extended sum of all slots; owidth leaves room for the carries.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(size); i++) begin
      sum_c = sum_c + owidth'(slot[i]);
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nx   = state;
    rd_nx      = rd_in_fifo;
    wr_nx      = 1'b0;
    fc_nx      = 1'b0;
    mode_nx    = next_mode_out;
    pend_nx    = pend_mode;
    rd_cnt_nx  = rd_cnt;
    cap_idx_nx = cap_vld ? cap_idx + cw'(1) : cap_idx;
    sum_nx     = sum_q;
    dout_nx    = data_out;
    case (state)
      ST_IDLE: begin
        if (invoke) begin
          case (next_mode_in)
            MODE_SETUP: begin
              state_nx   = ST_READ;
              rd_nx      = 1'b1;
              rd_cnt_nx  = '0;
              cap_idx_nx = '0;
            end
            MODE_COMP:   state_nx = ST_COMP;
            MODE_OUTPUT: state_nx = ST_WRITE;
            default: begin
              state_nx = ST_DONE;
              pend_nx  = MODE_SETUP;
            end
          endcase
        end
      end
      ST_READ: begin
        rd_cnt_nx = rd_cnt + cw'(1);
        if (rd_cnt == cw'(size - 1)) begin
          rd_nx    = 1'b0;
          state_nx = ST_CAPTURE;
        end
      end
      // Last pop's data lands during this cycle.
      ST_CAPTURE: begin
        state_nx = ST_DONE;
        pend_nx  = MODE_COMP;
      end
      ST_COMP: begin
        sum_nx   = sum_c;
        fc_nx    = 1'b1;
        mode_nx  = MODE_OUTPUT;
        state_nx = ST_IDLE;
      end
      ST_WRITE: begin
        wr_nx    = 1'b1;
        dout_nx  = sum_q;
        pend_nx  = MODE_SETUP;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        fc_nx    = 1'b1;
        mode_nx  = pend_mode;
        state_nx = ST_IDLE;
      end
      default: begin
        rd_nx    = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rd_cnt        <= '0;
      cap_idx       <= '0;
      cap_vld       <= 1'b0;
      pend_mode     <= MODE_SETUP;
      sum_q         <= '0;
      rd_in_fifo    <= 1'b0;
      wr_out_fifo   <= 1'b0;
      FC            <= 1'b0;
      next_mode_out <= MODE_SETUP;
      data_out      <= '0;
      for (int i = 0; i < int'(size); i++) begin
        slot[i] <= '0;
      end
    end else begin
      state         <= state_nx;
      rd_cnt        <= rd_cnt_nx;
      cap_idx       <= cap_idx_nx;
      cap_vld       <= rd_in_fifo;
      pend_mode     <= pend_nx;
      sum_q         <= sum_nx;
      rd_in_fifo    <= rd_nx;
      wr_out_fifo   <= wr_nx;
      FC            <= fc_nx;
      next_mode_out <= mode_nx;
      data_out      <= dout_nx;
      // FIFO read data is valid the cycle after each pop.
      if (cap_vld) begin
        slot[cap_idx] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_stream_comp_invoke.sv
// Bench for stream_comp_invoke: FIFO model plus a firing-level reference model
// (slots, latched sum, emitted value, mode) checked at every firing.
module tb_stream_comp_invoke;

  localparam int unsigned SIZE  = 3;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned OW    = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             invoke;
  logic [1:0]       next_mode_in;
  logic [WIDTH-1:0] data_in;
  logic             rd_in_fifo;
  logic             wr_out_fifo;
  logic [OW-1:0]    data_out;
  logic [1:0]       next_mode_out;
  logic             FC;

  stream_comp_invoke #(.size(SIZE), .width(WIDTH)) dut (
    .clk(clk), .rst(rst), .invoke(invoke), .next_mode_in(next_mode_in),
    .data_in(data_in), .rd_in_fifo(rd_in_fifo), .wr_out_fifo(wr_out_fifo),
    .data_out(data_out), .next_mode_out(next_mode_out), .FC(FC)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fq[$];
  longint           mslot [SIZE];
  longint           msum;
  longint           mdout;
  logic [1:0]       mmode;
  int               last_fc_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of the FC cycle (or on timeout).
  task automatic fire(input logic [1:0] mode, input bit hold,
                      output int fc_at, output int rd_n, output int wr_n, output int wr_at,
                      output logic [OW-1:0] dout, output bit overlap, output bit moved,
                      output int e0c, output int fcc);
    logic [1:0] m0;
    bit pop_pend;
    fc_at = -1; rd_n = 0; wr_n = 0; wr_at = -1; dout = '0;
    overlap = 0; moved = 0; e0c = 0; fcc = 0; pop_pend = 0;
    m0 = next_mode_out;
    invoke = 1'b1;
    next_mode_in = mode;
    @(posedge clk);
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 0) e0c = cyc;
      if (pop_pend) data_in = (fq.size() > 0) ? fq.pop_front() : 16'h0;
      pop_pend = rd_in_fifo;
      if (!hold && n == 0) invoke = 1'b0;
      if (rd_in_fifo) rd_n++;
      if (wr_out_fifo) begin
        wr_n++;
        wr_at = n;
        dout = data_out;
      end
      if (rd_in_fifo && wr_out_fifo) overlap = 1;
      if (FC) begin
        fc_at = n;
        fcc = cyc;
        break;
      end
      if (next_mode_out !== m0) moved = 1;
    end
  endtask

  task automatic do_fire(input logic [1:0] mode, input bit hold, input bit chained, input string tag);
    int fc_at, rd_n, wr_n, wr_at, e0c, fcc;
    int exp_fc, exp_rd, exp_wr;
    logic [OW-1:0] dout;
    logic [1:0] exp_mode;
    bit ov, mv;
    case (mode)
      2'b00: begin
        exp_fc = SIZE + 2; exp_rd = SIZE; exp_wr = 0; exp_mode = 2'b01;
        for (int k = 0; k < SIZE; k++) mslot[k] = (k < fq.size()) ? longint'(fq[k]) : 0;
      end
      2'b01: begin
        exp_fc = 1; exp_rd = 0; exp_wr = 0; exp_mode = 2'b10;
        msum = 0;
        for (int k = 0; k < SIZE; k++) msum += mslot[k];
      end
      2'b10: begin
        exp_fc = 2; exp_rd = 0; exp_wr = 1; exp_mode = 2'b00;
        mdout = msum;
      end
      default: begin
        exp_fc = 1; exp_rd = 0; exp_wr = 0; exp_mode = 2'b00;
      end
    endcase
    fire(mode, hold, fc_at, rd_n, wr_n, wr_at, dout, ov, mv, e0c, fcc);
    chk($sformatf("%s_fc_edge", tag), 64'(fc_at), 64'(exp_fc));
    chk($sformatf("%s_rd_pulses", tag), 64'(rd_n), 64'(exp_rd));
    chk($sformatf("%s_wr_pulses", tag), 64'(wr_n), 64'(exp_wr));
    chk($sformatf("%s_mode", tag), 64'(next_mode_out), 64'(exp_mode));
    chk($sformatf("%s_mode_early", tag), 64'(mv), 64'(0));
    chk($sformatf("%s_rd_wr_overlap", tag), 64'(ov), 64'(0));
    if (mode == 2'b10) begin
      chk($sformatf("%s_wr_edge", tag), 64'(wr_at), 64'(1));
      chk($sformatf("%s_wr_data", tag), 64'(dout), 64'(mdout));
    end
    chk($sformatf("%s_data_out", tag), 64'(data_out), 64'(mdout));
    if (chained) chk($sformatf("%s_no_gap", tag), 64'(e0c), 64'(last_fc_cyc + 1));
    last_fc_cyc = fcc;
    mmode = exp_mode;
  endtask

  // Quiet cycles: no strobes, outputs hold.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_fc_low", tag), 64'(FC), 64'(0));
      chk($sformatf("%s_rd_low", tag), 64'(rd_in_fifo), 64'(0));
      chk($sformatf("%s_wr_low", tag), 64'(wr_out_fifo), 64'(0));
      chk($sformatf("%s_hold_data", tag), 64'(data_out), 64'(mdout));
      chk($sformatf("%s_hold_mode", tag), 64'(next_mode_out), 64'(mmode));
    end
  endtask

  initial begin
    rst = 1'b1; invoke = 1'b0; next_mode_in = 2'b00; data_in = '0;
    msum = 0; mdout = 0; mmode = 2'b00; last_fc_cyc = 0;
    for (int k = 0; k < SIZE; k++) mslot[k] = 0;

    // Reset held for three cycles
    @(negedge clk);
    chk("rst_rd", 64'(rd_in_fifo), 64'(0));
    chk("rst_fc", 64'(FC), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_rd", 64'(rd_in_fifo), 64'(0));
    chk("post_rst_wr", 64'(wr_out_fifo), 64'(0));
    chk("post_rst_fc", 64'(FC), 64'(0));
    chk("post_rst_data", 64'(data_out), 64'(0));
    chk("post_rst_mode", 64'(next_mode_out), 64'(0));

    // Directed full cycle, first invoke right after reset release
    fq.push_back(16'd5); fq.push_back(16'd7); fq.push_back(16'd9);
    do_fire(2'b00, 0, 0, "setup579");
    idle(2, "gap1");
    do_fire(2'b01, 0, 0, "comp579");
    idle(1, "gap2");
    do_fire(2'b10, 0, 0, "out579");
    chk("out579_value", 64'(data_out), 64'(21));
    idle(3, "hold21");

    // Maximum tokens
    repeat (SIZE) fq.push_back(16'hffff);
    do_fire(2'b00, 0, 0, "setup_max");
    do_fire(2'b01, 0, 1, "comp_max");
    do_fire(2'b10, 0, 1, "out_max");
    chk("out_max_value", 64'(data_out), 64'(196605));
    idle(2, "gap3");

    // Invalid mode, then repeated COMP over the same slots
    do_fire(2'b11, 0, 0, "invalid");
    idle(1, "gap4");
    do_fire(2'b01, 0, 0, "comp_rep1");
    do_fire(2'b10, 0, 1, "out_rep1");
    do_fire(2'b01, 0, 1, "comp_rep2");
    do_fire(2'b10, 0, 1, "out_rep2");
    chk("repeat_value", 64'(data_out), 64'(196605));
    idle(2, "gap5");

    // invoke held through a SETUP firing: retrigger only after FC
    repeat (2 * SIZE) fq.push_back(16'($urandom));
    do_fire(2'b00, 1, 0, "setup_hold");
    do_fire(2'b00, 0, 1, "setup_retrig");
    do_fire(2'b01, 0, 1, "comp_retrig");
    do_fire(2'b10, 0, 1, "out_retrig");
    idle(2, "gap6");

    // Randomized back-to-back SETUP/COMP/OUTPUT chains
    for (int it = 0; it < 12; it++) begin
      repeat (SIZE) fq.push_back(($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom));
      do_fire(2'b00, 0, it > 0, "rnd_setup");
      do_fire(2'b01, 0, 1, "rnd_comp");
      if ($urandom_range(0, 1) == 1) do_fire(2'b01, 0, 1, "rnd_comp2");
      if ($urandom_range(0, 3) == 0) do_fire(2'b11, 0, 1, "rnd_inv");
      do_fire(2'b10, 0, 1, "rnd_out");
    end
    idle(2, "gap7");

    // Reset asserted mid-SETUP aborts the firing
    repeat (SIZE) fq.push_back(16'($urandom));
    do_fire(2'b00, 0, 0, "setup_pre");
    repeat (SIZE) fq.push_back(16'($urandom));
    invoke = 1'b1; next_mode_in = 2'b00;
    @(posedge clk);
    @(negedge clk);
    invoke = 1'b0;
    chk("abort_rd_active", 64'(rd_in_fifo), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rd_drop", 64'(rd_in_fifo), 64'(0));
    chk("abort_mode", 64'(next_mode_out), 64'(0));
    chk("abort_data", 64'(data_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fq.delete();
    for (int k = 0; k < SIZE; k++) mslot[k] = 0;
    msum = 0; mdout = 0; mmode = 2'b00;
    idle(8, "abort_no_fc");

    // Slots and sum were cleared by reset
    do_fire(2'b01, 0, 0, "comp_after_rst");
    do_fire(2'b10, 0, 1, "out_after_rst");
    chk("after_rst_value", 64'(data_out), 64'(0));
    idle(2, "tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
